// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side hazard handshake bundle between ID decoder and hazard controller.
// master drives the ID fields and branch outcome; slave returns pipeline controls.
interface pipeline_hazard_ctrl_if #(
  parameter int REGW = 5,
  parameter int CNTW = 32
);
  logic            id_valid;
  logic [REGW-1:0] id_rs1;
  logic [REGW-1:0] id_rs2;
  logic [REGW-1:0] id_rd;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic            id_writes_rd;
  logic            id_is_load;
  logic            id_is_halt;
  logic            ex_branch_taken;
  logic            stall;
  logic            flush;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            fetch_en;
  logic            halt_done;
  logic [CNTW-1:0] stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd,
    output id_use_rs1, id_use_rs2, id_writes_rd,
    output id_is_load, id_is_halt, ex_branch_taken,
    input  stall, flush, fwd_a, fwd_b,
    input  fetch_en, halt_done, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd,
    input  id_use_rs1, id_use_rs2, id_writes_rd,
    input  id_is_load, id_is_halt, ex_branch_taken,
    output stall, flush, fwd_a, fwd_b,
    output fetch_en, halt_done, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding/HALT-drain controller for the 5-stage pipeline.
// Optional macro PIPE_FORWARDING_EN enables EX operand forwarding.
module pipeline_hazard_ctrl #(
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] rd;
    logic            writes;
    logic            is_load;
  } slot_t;

  typedef struct packed {
    slot_t           s;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic            use_rs1;
    logic            use_rs2;
  } ex_slot_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  ex_slot_t        ex_q, ex_d;
  slot_t           mem_q, wb_q;
  state_e          state_q, state_d;
  logic [1:0]      dcnt_q, dcnt_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            hazard, stall, flush;
  logic [1:0]      fwd_a, fwd_b;
  logic            fetch_en, halt_done;
  logic            unused_slot_bits;

  function automatic logic hit(
    slot_t s, logic use_r, logic [REGW-1:0] r
  );
    return use_r & s.valid & s.writes & (s.rd == r);
  endfunction

`ifdef PIPE_FORWARDING_EN
  always_comb begin
    hazard = hz.id_valid & ex_q.s.valid & ex_q.s.is_load &
             ((hz.id_use_rs1 & (ex_q.s.rd == hz.id_rs1)) |
              (hz.id_use_rs2 & (ex_q.s.rd == hz.id_rs2)));
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (hit(mem_q, ex_q.use_rs1, ex_q.rs1))
      fwd_a = FWD_MEM;
    else if (hit(wb_q, ex_q.use_rs1, ex_q.rs1))
      fwd_a = FWD_WB;
    if (hit(mem_q, ex_q.use_rs2, ex_q.rs2))
      fwd_b = FWD_MEM;
    else if (hit(wb_q, ex_q.use_rs2, ex_q.rs2))
      fwd_b = FWD_WB;
  end
`else
  // WB is safe: the regfile writes in the first half-cycle.
  always_comb begin
    hazard = hz.id_valid &
             (hit(ex_q.s, hz.id_use_rs1, hz.id_rs1) |
              hit(ex_q.s, hz.id_use_rs2, hz.id_rs2) |
              hit(mem_q,  hz.id_use_rs1, hz.id_rs1) |
              hit(mem_q,  hz.id_use_rs2, hz.id_rs2));
    fwd_a  = FWD_RF;
    fwd_b  = FWD_RF;
  end
`endif

  assign flush = hz.ex_branch_taken;
  assign stall = hazard & ~flush;

  always_comb begin
    ex_d = '0;
    if (hz.id_valid & ~stall & ~flush &
        (state_q == RUN)) begin
      ex_d.s.valid   = 1'b1;
      ex_d.s.rd      = hz.id_rd;
      ex_d.s.writes  = hz.id_writes_rd;
      ex_d.s.is_load = hz.id_is_load;
      ex_d.rs1       = hz.id_rs1;
      ex_d.rs2       = hz.id_rs2;
      ex_d.use_rs1   = hz.id_use_rs1;
      ex_d.use_rs2   = hz.id_use_rs2;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1))
      cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
      dcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q.s;
      wb_q    <= mem_q;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Drain counts the HALT through EX, MEM and WB.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      RUN: begin
        if (hz.id_valid & hz.id_is_halt &
            ~stall & ~flush) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        if (dcnt_q == 2'd2) begin
          state_d = HALTED;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      HALTED: state_d = HALTED;
      default: begin
        state_d = RUN;
        dcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    fetch_en  = 1'b1;
    halt_done = 1'b0;
    unique case (state_q)
      RUN:    fetch_en = 1'b1;
      DRAIN:  fetch_en = 1'b0;
      HALTED: begin
        fetch_en  = 1'b0;
        halt_done = 1'b1;
      end
      default: fetch_en = 1'b1;
    endcase
  end

  assign hz.stall       = stall;
  assign hz.flush       = flush;
  assign hz.fwd_a       = fwd_a;
  assign hz.fwd_b       = fwd_b;
  assign hz.fetch_en    = fetch_en;
  assign hz.halt_done   = halt_done;
  assign hz.stall_count = cnt_q;

  assign unused_slot_bits = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl.
// Expected controls are queued per cycle and checked by a negedge monitor.
module tb_pipeline_hazard_ctrl;
  localparam int REGW = 5;
  localparam int CNTW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REGW(REGW), .CNTW(CNTW)) bus ();

  pipeline_hazard_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (bus)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       wr;
    logic       ld;
    logic       ht;
    logic       br;
  } vec_t;

  typedef struct packed {
    logic            stall;
    logic            flush;
    logic [1:0]      fa;
    logic [1:0]      fb;
    logic            fe;
    logic            hd;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   id_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   vec_n = 0;
  exp_t mx, ma;
  int   mn;

  function automatic vec_t nop();
    return '0;
  endfunction

  function automatic vec_t alu(int rd, int rs1, int rs2);
    vec_t v = '0;
    v.v = 1'b1; v.rd = 5'(rd);
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.u1 = 1'b1; v.u2 = 1'b1; v.wr = 1'b1;
    return v;
  endfunction

  function automatic vec_t ldw(int rd, int base);
    vec_t v = '0;
    v.v = 1'b1; v.rd = 5'(rd); v.rs1 = 5'(base);
    v.u1 = 1'b1; v.wr = 1'b1; v.ld = 1'b1;
    return v;
  endfunction

  function automatic vec_t hlt();
    vec_t v = '0;
    v.v = 1'b1; v.ht = 1'b1;
    return v;
  endfunction

  function automatic vec_t br(vec_t v);
    vec_t r = v;
    r.br = 1'b1;
    return r;
  endfunction

  function automatic exp_t e(
    logic st, logic fl, logic [1:0] fa, logic [1:0] fb,
    logic fe, logic hd, int c
  );
    exp_t x;
    x.stall = st; x.flush = fl; x.fa = fa; x.fb = fb;
    x.fe = fe; x.hd = hd; x.cnt = CNTW'(c);
    return x;
  endfunction

  task automatic step(input logic rst, input vec_t v, input exp_t x);
    @(posedge clk);
    #1;
    rst_n               = rst;
    bus.id_valid        = v.v;
    bus.id_rs1          = v.rs1;
    bus.id_rs2          = v.rs2;
    bus.id_rd           = v.rd;
    bus.id_use_rs1      = v.u1;
    bus.id_use_rs2      = v.u2;
    bus.id_writes_rd    = v.wr;
    bus.id_is_load      = v.ld;
    bus.id_is_halt      = v.ht;
    bus.ex_branch_taken = v.br;
    exp_q.push_back(x);
    id_q.push_back(vec_n);
    vec_n++;
  endtask

  task automatic halt_seq(input int b);
    step(1, hlt(),       e(0, 0, 0, 0, 1, 0, b));
    step(1, nop(),       e(0, 0, 0, 0, 0, 0, b));
    step(1, nop(),       e(0, 0, 0, 0, 0, 0, b));
    step(1, nop(),       e(0, 0, 0, 0, 0, 0, b));
    step(1, nop(),       e(0, 0, 0, 0, 0, 1, b));
    step(1, alu(1,2,3),  e(0, 0, 0, 0, 0, 1, b));
    step(0, nop(),       e(0, 0, 0, 0, 1, 0, 0));
    step(1, hlt(),       e(0, 0, 0, 0, 1, 0, 0));
    step(1, nop(),       e(0, 0, 0, 0, 0, 0, 0));
    step(0, nop(),       e(0, 0, 0, 0, 1, 0, 0));
    step(1, nop(),       e(0, 0, 0, 0, 1, 0, 0));
    step(1, nop(),       e(0, 0, 0, 0, 1, 0, 0));
    step(1, nop(),       e(0, 0, 0, 0, 1, 0, 0));
    step(1, br(hlt()),   e(0, 1, 0, 0, 1, 0, 0));
    step(1, nop(),       e(0, 0, 0, 0, 1, 0, 0));
    step(1, nop(),       e(0, 0, 0, 0, 1, 0, 0));
    step(1, nop(),       e(0, 0, 0, 0, 1, 0, 0));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      mn = id_q.pop_front();
      ma = {bus.stall, bus.flush, bus.fwd_a, bus.fwd_b,
            bus.fetch_en, bus.halt_done, bus.stall_count};
      compared++;
      if (ma !== mx) begin
        mismatched++;
        $display("FAIL vec%0d: got stall=%0b flush=%0b fwd_a=%0d fwd_b=%0d fetch_en=%0b halt_done=%0b cnt=%0d; required stall=%0b flush=%0b fwd_a=%0d fwd_b=%0d fetch_en=%0b halt_done=%0b cnt=%0d",
                 mn, ma.stall, ma.flush, ma.fa, ma.fb, ma.fe,
                 ma.hd, ma.cnt, mx.stall, mx.flush, mx.fa,
                 mx.fb, mx.fe, mx.hd, mx.cnt);
      end
    end
  end

  initial begin
    int k;
    bus.id_valid        = 1'b0;
    bus.id_rs1          = '0;
    bus.id_rs2          = '0;
    bus.id_rd           = '0;
    bus.id_use_rs1      = 1'b0;
    bus.id_use_rs2      = 1'b0;
    bus.id_writes_rd    = 1'b0;
    bus.id_is_load      = 1'b0;
    bus.id_is_halt      = 1'b0;
    bus.ex_branch_taken = 1'b0;

    step(0, alu(1,2,3), e(0, 0, 0, 0, 1, 0, 0));

`ifdef PIPE_FORWARDING_EN
    step(1, alu(1,2,3),     e(0, 0, 0, 0, 1, 0, 0));
    step(1, alu(4,1,5),     e(0, 0, 0, 0, 1, 0, 0));
    step(1, nop(),          e(0, 0, 1, 0, 1, 0, 0));
    step(1, nop(),          e(0, 0, 0, 0, 1, 0, 0));
    step(1, nop(),          e(0, 0, 0, 0, 1, 0, 0));
    step(1, ldw(2,6),       e(0, 0, 0, 0, 1, 0, 0));
    step(1, alu(3,2,2),     e(1, 0, 0, 0, 1, 0, 0));
    step(1, alu(3,2,2),     e(0, 0, 0, 0, 1, 0, 1));
    step(1, nop(),          e(0, 0, 2, 2, 1, 0, 1));
    step(1, alu(7,1,1),     e(0, 0, 0, 0, 1, 0, 1));
    step(1, alu(7,1,1),     e(0, 0, 0, 0, 1, 0, 1));
    step(1, alu(8,7,9),     e(0, 0, 0, 0, 1, 0, 1));
    step(1, nop(),          e(0, 0, 1, 0, 1, 0, 1));
    step(1, alu(9,5,8),     e(0, 0, 0, 0, 1, 0, 1));
    step(1, nop(),          e(0, 0, 0, 2, 1, 0, 1));
    step(1, nop(),          e(0, 0, 0, 0, 1, 0, 1));
    step(1, nop(),          e(0, 0, 0, 0, 1, 0, 1));
    step(1, ldw(2,6),       e(0, 0, 0, 0, 1, 0, 1));
    step(1, br(alu(3,2,2)), e(0, 1, 0, 0, 1, 0, 1));
    step(1, nop(),          e(0, 0, 0, 0, 1, 0, 1));
    step(1, nop(),          e(0, 0, 0, 0, 1, 0, 1));
    halt_seq(1);
`else
    step(1, alu(1,2,3),     e(0, 0, 0, 0, 1, 0, 0));
    step(1, alu(4,1,5),     e(1, 0, 0, 0, 1, 0, 0));
    step(1, alu(4,1,5),     e(1, 0, 0, 0, 1, 0, 1));
    step(1, alu(4,1,5),     e(0, 0, 0, 0, 1, 0, 2));
    step(1, nop(),          e(0, 0, 0, 0, 1, 0, 2));
    step(1, nop(),          e(0, 0, 0, 0, 1, 0, 2));
    step(1, nop(),          e(0, 0, 0, 0, 1, 0, 2));
    step(1, ldw(2,6),       e(0, 0, 0, 0, 1, 0, 2));
    step(1, br(alu(3,2,2)), e(0, 1, 0, 0, 1, 0, 2));
    step(1, nop(),          e(0, 0, 0, 0, 1, 0, 2));
    step(1, nop(),          e(0, 0, 0, 0, 1, 0, 2));
    step(1, ldw(2,6),       e(0, 0, 0, 0, 1, 0, 2));
    step(1, alu(3,2,2),     e(1, 0, 0, 0, 1, 0, 2));
    step(1, alu(3,2,2),     e(1, 0, 0, 0, 1, 0, 3));
    step(1, alu(3,2,2),     e(0, 0, 0, 0, 1, 0, 3));
    step(1, nop(),          e(0, 0, 0, 0, 1, 0, 3));
    step(1, nop(),          e(0, 0, 0, 0, 1, 0, 3));
    halt_seq(3);
`endif

    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
